// File: rtl/puf_soc_pkg.sv
// Shared types and default constants for the RO-PUF execution scheduler.
package puf_soc_pkg;

    localparam int unsigned DEF_MUX_LENGTH    = 16;
    localparam int unsigned DEF_NUM_PAIRS     = 4;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_WINDOW_CYCLES = 32;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } sched_state_e;

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter; expire_o is high in the last cycle of a loaded interval.
module puf_window_timer #(
    parameter int unsigned TMR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             expire_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    // expire is registered from the next count so it lines up with cnt_q == 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= (cnt_d == TMR_W'(1));
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/puf_ro_exec_sched.sv
// RO-PUF execution scheduler: walks the challenge pairs, times each RO window
// and builds the response, max-count and pair-error results.
module puf_ro_exec_sched
    import puf_soc_pkg::*;
#(
    parameter int unsigned MUX_LENGTH    = DEF_MUX_LENGTH,
    parameter int unsigned NUM_PAIRS     = DEF_NUM_PAIRS,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int unsigned SW           = $clog2(MUX_LENGTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_exec_enable,
    input  logic                      i_abort,
    input  logic [NUM_PAIRS*2*SW-1:0] i_challenge,
    input  logic [CNT_W-1:0]          i_ro_cnt_0,
    input  logic [CNT_W-1:0]          i_ro_cnt_1,
    output logic [SW-1:0]             o_sel_mux_0,
    output logic [SW-1:0]             o_sel_mux_1,
    output logic                      o_cnt_clr,
    output logic                      o_ro_en,
    output logic                      o_busy,
    output logic                      o_exec_done,
    output logic [NUM_PAIRS-1:0]      o_response,
    output logic [CNT_W-1:0]          o_max_count,
    output logic [NUM_PAIRS-1:0]      o_pair_err
);

    localparam int unsigned PAIR_W  = 2 * SW;
    localparam int unsigned CHAL_W  = NUM_PAIRS * PAIR_W;
    localparam int unsigned PIDX_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int unsigned TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    sched_state_e         state_q, state_d;
    logic [PIDX_W-1:0]    pair_q, pair_d;
    logic [CHAL_W-1:0]    chal_q, chal_d;
    logic [SW-1:0]        sel0_q, sel0_d, sel1_q, sel1_d;
    logic                 cnt_clr_q, cnt_clr_d, ro_en_q, ro_en_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [NUM_PAIRS-1:0] resp_q, resp_d, err_q, err_d;
    logic [CNT_W-1:0]     max_q, max_d;
    logic [CNT_W-1:0]     smp_max;
    logic [PAIR_W-1:0]    next_pair_sel;
    logic                 sel_eq, tmr_load, tmr_expire;
    logic [TMR_W-1:0]     tmr_val;

    assign sel_eq  = (sel0_q == sel1_q);
    assign smp_max = (i_ro_cnt_0 > i_ro_cnt_1) ? i_ro_cnt_0 : i_ro_cnt_1;

    always_comb begin
        state_d       = state_q;
        pair_d        = pair_q;
        chal_d        = chal_q;
        resp_d        = resp_q;
        err_d         = err_q;
        max_d         = max_q;
        sel0_d        = sel0_q;
        sel1_d        = sel1_q;
        tmr_val       = '0;
        next_pair_sel = '0;

        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_exec_enable) begin
                        chal_d  = i_challenge;
                        pair_d  = '0;
                        resp_d  = '0;
                        err_d   = '0;
                        max_d   = '0;
                        state_d = ST_CLEAR;
                    end
                end
                // a degenerate pair has nothing to race, so skip straight to SAMPLE
                ST_CLEAR:  state_d = sel_eq ? ST_SAMPLE : ST_RUN;
                ST_RUN:    if (tmr_expire) state_d = ST_SETTLE;
                ST_SETTLE: if (tmr_expire) state_d = ST_SAMPLE;
                ST_SAMPLE: begin
                    if (sel_eq) begin
                        err_d[pair_q]  = 1'b1;
                        resp_d[pair_q] = 1'b0;
                    end else begin
                        resp_d[pair_q] = (i_ro_cnt_0 > i_ro_cnt_1);
                        if (smp_max > max_q) max_d = smp_max;
                    end
                    if (pair_q == PIDX_W'(NUM_PAIRS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        pair_d  = pair_q + PIDX_W'(1);
                        state_d = ST_CLEAR;
                    end
                end
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end

        // outputs are registered from the next state so they align with it
        cnt_clr_d = (state_d == ST_CLEAR);
        ro_en_d   = (state_d == ST_RUN);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);

        next_pair_sel = chal_d[32'(pair_d) * PAIR_W +: PAIR_W];
        if (state_d inside {ST_CLEAR, ST_RUN, ST_SETTLE, ST_SAMPLE}) begin
            sel0_d = next_pair_sel[SW-1:0];
            sel1_d = next_pair_sel[PAIR_W-1:SW];
        end

        // timer reloads on every state change, zero outside the timed states
        tmr_load = (state_d != state_q);
        if (state_d == ST_RUN)    tmr_val = TMR_W'(WINDOW_CYCLES);
        if (state_d == ST_SETTLE) tmr_val = TMR_W'(SETTLE_CYCLES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pair_q    <= '0;
            chal_q    <= '0;
            sel0_q    <= '0;
            sel1_q    <= '0;
            cnt_clr_q <= 1'b0;
            ro_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= '0;
            err_q     <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            pair_q    <= pair_d;
            chal_q    <= chal_d;
            sel0_q    <= sel0_d;
            sel1_q    <= sel1_d;
            cnt_clr_q <= cnt_clr_d;
            ro_en_q   <= ro_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
            max_q     <= max_d;
        end
    end

    puf_window_timer #(
        .TMR_W      (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    assign o_sel_mux_0 = sel0_q;
    assign o_sel_mux_1 = sel1_q;
    assign o_cnt_clr   = cnt_clr_q;
    assign o_ro_en     = ro_en_q;
    assign o_busy      = busy_q;
    assign o_exec_done = done_q;
    assign o_response  = resp_q;
    assign o_max_count = max_q;
    assign o_pair_err  = err_q;

endmodule
